apb_regfile_slave: RTL
======================

# apb_regfile_slave

APB3/APB4 completer register bank that sits directly downstream of the AXI4-Lite-to-APB bridge, on one `psel` slot. It holds `NUM_REGS` 32-bit word registers with byte-strobe writes and a programmable wait-state count. It reports `pslverr` for out-of-range, misaligned or read-only-violating accesses. It drives `pready`, `prdata` and `pslverr` to zero whenever it is not completing a transfer, so the bridge can OR-combine `pready` and the shared `pslverr` across slots.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_0000, byte address of register 0; must match the bridge's lower region bound for this slot.
- `NUM_REGS`, 16, number of word registers (1..64).
- `WAIT_STATES`, 2, extra access cycles before `pready` (0..8); must stay below the bridge timeout.
- `RO_MASK`, 0, bit i=1 makes register i read-only; bits at or above NUM_REGS are ignored.
- `RESET_VAL`, 32'h0, reset value of every register.

Ports:
- `s_axi_clk` input 1: single clock, rising edge.
- `s_axi_aresetn` input 1: asynchronous, active-low reset.
- `s_apb_psel` input 1: this slot's select bit from the bridge.
- `s_apb_penable` input 1: access phase.
- `s_apb_pwrite` input 1: 1 = write.
- `s_apb_paddr` input 32: byte address.
- `s_apb_pwdata` input 32: write data.
- `s_apb_pstrb` input 4: byte lane enables for writes.
- `s_apb_pprot` input 3: accepted and ignored.
- `s_apb_pready` output 1: transfer completes this cycle.
- `s_apb_prdata` output 32: read data, valid only with `pready` on a read.
- `s_apb_pslverr` output 1: error, valid only with `pready`.

## Operation
- States: IDLE, ACCESS. Use a 4-bit `wait_cnt`.
- IDLE:
  - On `psel & !penable` (setup phase), latch `paddr`, `pwrite`, `pwdata` and `pstrb`.
  - Load `wait_cnt <= WAIT_STATES`.
  - Go to ACCESS.
- ACCESS:
  - If `psel` is 0, abort: go to IDLE, commit nothing, assert no outputs.
  - Else if `wait_cnt != 0`, decrement it and hold `pready = 0`.
  - Else (`wait_cnt == 0`), assert `pready`. At that edge, commit the transfer and return to IDLE.
- Decode uses the latched address only:
  - `offset = addr - BASE_ADDR` (32-bit, unsigned). `idx = offset[31:2]`.
  - `hit = (addr >= BASE_ADDR) && (idx < NUM_REGS)`.
- Error conditions, all evaluated on the latched request:
  - `!hit`.
  - `addr[1:0] != 0`.
  - A write to register `idx` with `RO_MASK[idx]` set.
- Write with no error: for each lane b with `pstrb[b]=1`, `reg[idx][8b+7:8b] <= wdata[8b+7:8b]`. `pstrb == 0` is a legal no-op with `pslverr = 0`.
- Write with error: no register changes.
- Read with no error: `prdata = reg[idx]`. Read with error: `prdata = 0`.
- `pslverr` and `prdata` are combinational from state and latched request, gated by `pready`. Outside the `pready` cycle they are 0.
- `s_apb_pready` is 0 whenever `psel` is 0, regardless of state.

## Timing
- Reset (asynchronous, any time, including mid-ACCESS):
  - State goes to IDLE and `wait_cnt` to 0.
  - All registers go to `RESET_VAL`.
  - `pready`, `prdata` and `pslverr` go to 0.
  - An in-flight write is dropped.
- Latency: setup at cycle T puts ACCESS at T+1. `pready` is high in cycle T+1+`WAIT_STATES`, for exactly one cycle.
- Write data is visible to a read whose setup phase is the cycle after `pready`.
- Back-to-back: a new setup in the cycle after `pready` is accepted from IDLE with no dead cycle.
- `paddr`, `pwrite` and `pwdata` changing during ACCESS are ignored, because the request is latched at setup.
- `penable` already high while in IDLE (no setup seen) is ignored; stay in IDLE.

## Test plan
- Reset, then read `BASE_ADDR+0x8` with `WAIT_STATES=2`: `pready` high on the 3rd access cycle, `prdata=RESET_VAL`, `pslverr=0`; outputs 0 on every other cycle.
- Write 0xA5A5_1234 to 0x4 with `pstrb=4'b0101` over prior value 0xFFFF_FFFF: read back 0xFFA5_FF34.
- Accesses that must error, with no state change:
  - Read 0x40 with `NUM_REGS=16`: `pslverr=1`, `prdata=0`.
  - Write to 0x2 (misaligned): `pslverr=1`, no register modified.
- `RO_MASK=16'h8000`:
  - Write 0x3C: `pslverr=1`, register 15 unchanged.
  - Read 0x3C: `RESET_VAL`, `pslverr=0`.
- Abort and reset mid-transfer:
  - Drop `psel` after one ACCESS cycle of a write: no `pready`, register unchanged, next setup accepted normally.
  - Assert `s_axi_aresetn=0` mid-ACCESS: all outputs 0 immediately, registers at `RESET_VAL`.
- Back-to-back with `WAIT_STATES=0`: write 0x1111_2222 to 0x0, then read 0x0 in the next setup. `pready` is high every second cycle and the read returns 0x1111_2222.

Source files
------------

// File: rtl/apb_regfile_slave.sv
// APB3/APB4 completer holding NUM_REGS word registers with byte-strobe writes,
// programmable wait states and pslverr on out-of-range, misaligned or read-only accesses.
module apb_regfile_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [63:0] RO_MASK     = 64'h0,
  parameter logic [31:0] RESET_VAL   = 32'h0
) (
  input  logic        s_axi_clk,
  input  logic        s_axi_aresetn,
  input  logic        s_apb_psel,
  input  logic        s_apb_penable,
  input  logic        s_apb_pwrite,
  input  logic [31:0] s_apb_paddr,
  input  logic [31:0] s_apb_pwdata,
  input  logic [3:0]  s_apb_pstrb,
  input  logic [2:0]  s_apb_pprot,
  output logic        s_apb_pready,
  output logic [31:0] s_apb_prdata,
  output logic        s_apb_pslverr
);

  localparam int unsigned IdxW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [3:0]  WaitInit = 4'(WAIT_STATES);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        latch_en;

  logic [31:0] addr_q, wdata_q;
  logic        write_q;
  logic [3:0]  strb_q;

  logic [31:0] regs_q [NUM_REGS];

  logic [31:0]     offset;
  logic [IdxW-1:0] idx_sel;
  logic            hit, ro_hit, err;
  logic            commit_wr;
  logic [31:0]     rdata;
  logic            unused;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    latch_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // penable already high without a setup phase is not a new transfer
        if (s_apb_psel && !s_apb_penable) begin
          state_d    = StAccess;
          wait_cnt_d = WaitInit;
          latch_en   = 1'b1;
        end
      end
      StAccess: begin
        if (!s_apb_psel) begin
          state_d = StIdle;
        end else if (wait_cnt_q != 4'd0) begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge s_axi_clk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q    <= StIdle;
      wait_cnt_q <= 4'd0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      write_q    <= 1'b0;
      strb_q     <= 4'h0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (latch_en) begin
        addr_q  <= s_apb_paddr;
        wdata_q <= s_apb_pwdata;
        write_q <= s_apb_pwrite;
        strb_q  <= s_apb_pstrb;
      end
    end
  end

  // Decode works purely from the request latched at setup.
  always_comb begin
    offset  = addr_q - BASE_ADDR;
    idx_sel = offset[IdxW+1:2];
    hit     = (addr_q >= BASE_ADDR) && ({2'b00, offset[31:2]} < 32'(NUM_REGS));
    ro_hit  = RO_MASK[offset[7:2]];
    err     = !hit || (addr_q[1:0] != 2'b00) || (write_q && ro_hit);
    rdata   = hit ? regs_q[idx_sel] : 32'h0;
  end

  assign s_apb_pready  = (state_q == StAccess) && s_apb_psel && (wait_cnt_q == 4'd0);
  assign s_apb_pslverr = s_apb_pready && err;
  assign s_apb_prdata  = (s_apb_pready && !write_q && !err) ? rdata : 32'h0;
  assign commit_wr     = s_apb_pready && write_q && !err;

  always_ff @(posedge s_axi_clk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else if (commit_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (strb_q[b]) begin
          regs_q[idx_sel][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign unused = ^{s_apb_pprot, offset[1:0]};

endmodule
